calendario_regresivo: RTL and testbench

BCD day/month calendar that counts backward one day per enabled clock, the down-counting counterpart of the forward calendar counter in the same design. It holds day units/tens and month units/tens as four BCD digits and borrows across the day and month boundaries using real month lengths. It can be preset through a validated load port, and reports year wrap-around and rejected loads with single-cycle pulses. Its digit outputs are directly compatible with the forward counter's digit outputs and feed the same display path.

---
 rtl/calendario_regresivo.sv | 141 ++++++++++++++
 tb/tb_calendario_regresivo.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/calendario_regresivo.sv
// Backward BCD day/month calendar: one day back per enabled clock, with a validated preset.
// Digit outputs match the forward calendar counter so both can share the display path.
module calendario_regresivo #(
  parameter int FEB_DAYS = 28
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       load,
  input  logic [3:0] ld_du,
  input  logic [3:0] ld_dd,
  input  logic [3:0] ld_mu,
  input  logic [3:0] ld_md,
  output logic [3:0] du,
  output logic [3:0] dd,
  output logic [3:0] mu,
  output logic [3:0] md,
  output logic       wrap,
  output logic       load_err
);

  localparam logic [3:0] FEB_UNITS = (FEB_DAYS == 29) ? 4'd9 : 4'd8;

  logic [3:0] du_q, du_d;
  logic [3:0] dd_q, dd_d;
  logic [3:0] mu_q, mu_d;
  logic [3:0] md_q, md_d;
  logic       wrap_q, wrap_d;
  logic       load_err_q, load_err_d;

  // Month length as two BCD digits {tens, units}
  function automatic logic [7:0] month_len(input logic [3:0] m_t, input logic [3:0] m_u);
    logic [7:0] len;
    if (m_t == 4'd0 && m_u == 4'd2) begin
      len = {4'd2, FEB_UNITS};
    end else if ((m_t == 4'd0 && (m_u == 4'd4 || m_u == 4'd6 || m_u == 4'd9)) ||
                 (m_t == 4'd1 && m_u == 4'd1)) begin
      len = {4'd3, 4'd0};
    end else begin
      len = {4'd3, 4'd1};
    end
    return len;
  endfunction

  logic [7:0] ld_len;
  logic       ld_digits_ok;
  logic       ld_month_ok;
  logic       ld_day_nonzero;
  logic       ld_day_fits;
  logic       ld_valid;

  assign ld_len         = month_len(ld_md, ld_mu);
  assign ld_digits_ok   = (ld_du <= 4'd9) && (ld_dd <= 4'd9) && (ld_mu <= 4'd9) && (ld_md <= 4'd1);
  assign ld_month_ok    = (ld_md == 4'd0 && ld_mu != 4'd0) || (ld_md == 4'd1 && ld_mu <= 4'd2);
  assign ld_day_nonzero = !(ld_dd == 4'd0 && ld_du == 4'd0);
  // Digit-wise BCD compare of the day against the month length
  assign ld_day_fits    = (ld_dd < ld_len[7:4]) ||
                          (ld_dd == ld_len[7:4] && ld_du <= ld_len[3:0]);
  assign ld_valid       = ld_digits_ok && ld_month_ok && ld_day_nonzero && ld_day_fits;

  logic [3:0] prev_mu;
  logic [3:0] prev_md;
  logic       prev_wraps;
  logic [7:0] prev_len;
  logic       day_is_first;

  always_comb begin
    prev_mu    = mu_q - 4'd1;
    prev_md    = md_q;
    prev_wraps = 1'b0;
    if (md_q == 4'd0 && mu_q == 4'd1) begin
      prev_md    = 4'd1;
      prev_mu    = 4'd2;
      prev_wraps = 1'b1;
    end else if (mu_q == 4'd0) begin
      prev_md = 4'd0;
      prev_mu = 4'd9;
    end
  end

  assign prev_len     = month_len(prev_md, prev_mu);
  assign day_is_first = (du_q == 4'd1) && (dd_q == 4'd0);

  always_comb begin
    du_d       = du_q;
    dd_d       = dd_q;
    mu_d       = mu_q;
    md_d       = md_q;
    wrap_d     = 1'b0;
    load_err_d = 1'b0;
    if (load) begin
      if (ld_valid) begin
        du_d = ld_du;
        dd_d = ld_dd;
        mu_d = ld_mu;
        md_d = ld_md;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (en) begin
      if (day_is_first) begin
        mu_d   = prev_mu;
        md_d   = prev_md;
        dd_d   = prev_len[7:4];
        du_d   = prev_len[3:0];
        wrap_d = prev_wraps;
      end else if (du_q == 4'd0) begin
        du_d = 4'd9;
        dd_d = dd_q - 4'd1;
      end else begin
        du_d = du_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      du_q       <= 4'd1;
      dd_q       <= 4'd0;
      mu_q       <= 4'd1;
      md_q       <= 4'd0;
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      du_q       <= du_d;
      dd_q       <= dd_d;
      mu_q       <= mu_d;
      md_q       <= md_d;
      wrap_q     <= wrap_d;
      load_err_q <= load_err_d;
    end
  end

  assign du       = du_q;
  assign dd       = dd_q;
  assign mu       = mu_q;
  assign md       = md_q;
  assign wrap     = wrap_q;
  assign load_err = load_err_q;

endmodule

// File: tb/tb_calendario_regresivo.sv
// Bench for calendario_regresivo: a 28-day and a 29-day February instance driven in parallel,
// checked against a day/month integer model plus a directed vector table.
module tb_calendario_regresivo;

  logic       clk;
  logic       rst;
  logic       en;
  logic       load;
  logic [3:0] ld_du, ld_dd, ld_mu, ld_md;
  logic [3:0] du_o [2];
  logic [3:0] dd_o [2];
  logic [3:0] mu_o [2];
  logic [3:0] md_o [2];
  logic       wr_o [2];
  logic       er_o [2];

  int n_chk = 0;
  int n_fail = 0;

  calendario_regresivo #(.FEB_DAYS(28)) dut28 (
    .clk(clk), .rst(rst), .en(en), .load(load),
    .ld_du(ld_du), .ld_dd(ld_dd), .ld_mu(ld_mu), .ld_md(ld_md),
    .du(du_o[0]), .dd(dd_o[0]), .mu(mu_o[0]), .md(md_o[0]),
    .wrap(wr_o[0]), .load_err(er_o[0])
  );

  calendario_regresivo #(.FEB_DAYS(29)) dut29 (
    .clk(clk), .rst(rst), .en(en), .load(load),
    .ld_du(ld_du), .ld_dd(ld_dd), .ld_mu(ld_mu), .ld_md(ld_md),
    .du(du_o[1]), .dd(dd_o[1]), .mu(mu_o[1]), .md(md_o[1]),
    .wrap(wr_o[1]), .load_err(er_o[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain integer day and month per instance
  int m_day [2];
  int m_mon [2];
  int m_wrap [2];
  int m_err [2];
  int feb [2] = '{28, 29};

  function automatic int mlen(input int k, input int m);
    case (m)
      2:             return feb[k];
      4, 6, 9, 11:   return 30;
      default:       return 31;
    endcase
  endfunction

  task automatic model_step(input int k, input logic r, input logic l, input logic e,
                            input int a_du, input int a_dd, input int a_mu, input int a_md);
    int mon, day;
    bit ok;
    m_wrap[k] = 0;
    m_err[k]  = 0;
    if (!r) begin
      m_day[k] = 1;
      m_mon[k] = 1;
    end else if (l) begin
      ok  = (a_du <= 9) && (a_dd <= 9) && (a_mu <= 9) && (a_md <= 1);
      mon = 10 * a_md + a_mu;
      day = 10 * a_dd + a_du;
      if (ok) ok = (mon >= 1) && (mon <= 12);
      if (ok) ok = (day >= 1) && (day <= mlen(k, mon));
      if (ok) begin
        m_day[k] = day;
        m_mon[k] = mon;
      end else begin
        m_err[k] = 1;
      end
    end else if (e) begin
      if (m_day[k] > 1) begin
        m_day[k] = m_day[k] - 1;
      end else begin
        if (m_mon[k] == 1) begin
          m_mon[k]  = 12;
          m_wrap[k] = 1;
        end else begin
          m_mon[k] = m_mon[k] - 1;
        end
        m_day[k] = mlen(k, m_mon[k]);
      end
    end
  endtask

  function automatic logic [17:0] got_vec(input int k);
    return {md_o[k], mu_o[k], dd_o[k], du_o[k], wr_o[k], er_o[k]};
  endfunction

  task automatic check(input string name, input logic [17:0] got, input logic [17:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got md/mu/dd/du/wrap/err=%h/%h/%h/%h/%b/%b required %h/%h/%h/%h/%b/%b",
               name, got[17:14], got[13:10], got[9:6], got[5:2], got[1], got[0],
               exp[17:14], exp[13:10], exp[9:6], exp[5:2], exp[1], exp[0]);
    end
  endtask

  task automatic check_model(input int k);
    logic [17:0] exp;
    exp = {4'(m_mon[k] / 10), 4'(m_mon[k] % 10), 4'(m_day[k] / 10), 4'(m_day[k] % 10),
           1'(m_wrap[k]), 1'(m_err[k])};
    check(k == 0 ? "model_feb28" : "model_feb29", got_vec(k), exp);
  endtask

  task automatic apply(input logic r, input logic l, input logic e,
                       input logic [3:0] a_du, input logic [3:0] a_dd,
                       input logic [3:0] a_mu, input logic [3:0] a_md);
    @(negedge clk);
    rst = r; load = l; en = e;
    ld_du = a_du; ld_dd = a_dd; ld_mu = a_mu; ld_md = a_md;
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      model_step(k, r, l, e, int'(a_du), int'(a_dd), int'(a_mu), int'(a_md));
      check_model(k);
    end
  endtask

  typedef struct {
    logic       r, l, e;
    logic [3:0] a_du, a_dd, a_mu, a_md;
    logic [17:0] x;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic l, input logic e,
                              input logic [3:0] a_du, input logic [3:0] a_dd,
                              input logic [3:0] a_mu, input logic [3:0] a_md,
                              input logic [3:0] x_du, input logic [3:0] x_dd,
                              input logic [3:0] x_mu, input logic [3:0] x_md,
                              input logic x_w, input logic x_e);
    vec_t v;
    v.r = r; v.l = l; v.e = e;
    v.a_du = a_du; v.a_dd = a_dd; v.a_mu = a_mu; v.a_md = a_md;
    v.x = {x_md, x_mu, x_dd, x_du, x_w, x_e};
    return v;
  endfunction

  vec_t tbl [21];
  int   wraps;

  initial begin
    rst = 1'b0; en = 1'b0; load = 1'b0;
    ld_du = 4'd0; ld_dd = 4'd0; ld_mu = 4'd0; ld_md = 4'd0;

    // expected outputs refer to the FEB_DAYS=28 instance
    //            r  l  e   du dd mu md      du dd mu md  w  e
    tbl[0]  = mk(0, 0, 0,  0, 0, 0, 0,     1, 0, 1, 0,  0, 0);
    tbl[1]  = mk(0, 0, 0,  0, 0, 0, 0,     1, 0, 1, 0,  0, 0);
    tbl[2]  = mk(1, 0, 1,  0, 0, 0, 0,     1, 3, 2, 1,  1, 0);
    tbl[3]  = mk(1, 0, 0,  0, 0, 0, 0,     1, 3, 2, 1,  0, 0);
    tbl[4]  = mk(1, 1, 0,  1, 0, 3, 0,     1, 0, 3, 0,  0, 0);
    tbl[5]  = mk(1, 0, 1,  0, 0, 0, 0,     8, 2, 2, 0,  0, 0);
    tbl[6]  = mk(1, 1, 0,  0, 1, 5, 0,     0, 1, 5, 0,  0, 0);
    tbl[7]  = mk(1, 0, 1,  0, 0, 0, 0,     9, 0, 5, 0,  0, 0);
    tbl[8]  = mk(1, 1, 0,  1, 0, 0, 1,     1, 0, 0, 1,  0, 0);
    tbl[9]  = mk(1, 0, 1,  0, 0, 0, 0,     0, 3, 9, 0,  0, 0);
    tbl[10] = mk(1, 1, 0,  1, 0, 1, 1,     1, 0, 1, 1,  0, 0);
    tbl[11] = mk(1, 0, 1,  0, 0, 0, 0,     1, 3, 0, 1,  0, 0);
    tbl[12] = mk(1, 1, 0,  1, 3, 4, 0,     1, 3, 0, 1,  0, 1);
    tbl[13] = mk(1, 1, 0,  0, 0, 5, 0,     1, 3, 0, 1,  0, 1);
    tbl[14] = mk(1, 1, 0,  5, 1, 3, 1,     1, 3, 0, 1,  0, 1);
    tbl[15] = mk(1, 1, 0, 10, 0, 1, 0,     1, 3, 0, 1,  0, 1);
    tbl[16] = mk(1, 0, 0,  0, 0, 0, 0,     1, 3, 0, 1,  0, 0);
    tbl[17] = mk(1, 1, 1,  5, 1, 6, 0,     5, 1, 6, 0,  0, 0);
    tbl[18] = mk(0, 1, 1,  0, 2, 7, 0,     1, 0, 1, 0,  0, 0);
    tbl[19] = mk(1, 0, 1,  0, 0, 0, 0,     1, 3, 2, 1,  1, 0);
    tbl[20] = mk(1, 1, 0,  9, 2, 2, 0,     1, 3, 2, 1,  0, 1);

    for (int i = 0; i < 21; i++) begin
      apply(tbl[i].r, tbl[i].l, tbl[i].e, tbl[i].a_du, tbl[i].a_dd, tbl[i].a_mu, tbl[i].a_md);
      check($sformatf("vec%0d", i), got_vec(0), tbl[i].x);
    end

    // Full year with 28-day February
    apply(1, 1, 0, 4'd1, 4'd3, 4'd2, 4'd1);
    wraps = 0;
    for (int i = 0; i < 365; i++) begin
      apply(1, 0, 1, 4'd0, 4'd0, 4'd0, 4'd0);
      if (wr_o[0]) wraps++;
    end
    check("sweep28_date", got_vec(0), {4'd1, 4'd2, 4'd3, 4'd1, wr_o[0], 1'b0});
    n_chk++;
    if (wraps != 1) begin
      n_fail++;
      $display("FAIL sweep28_wraps: got %0d required 1", wraps);
    end

    // Full year with 29-day February
    apply(1, 1, 0, 4'd1, 4'd3, 4'd2, 4'd1);
    wraps = 0;
    for (int i = 0; i < 366; i++) begin
      apply(1, 0, 1, 4'd0, 4'd0, 4'd0, 4'd0);
      if (wr_o[1]) wraps++;
    end
    check("sweep29_date", got_vec(1), {4'd1, 4'd2, 4'd3, 4'd1, wr_o[1], 1'b0});
    n_chk++;
    if (wraps != 1) begin
      n_fail++;
      $display("FAIL sweep29_wraps: got %0d required 1", wraps);
    end

    // Random traffic, mostly in-range digits so many loads are accepted
    for (int i = 0; i < 3000; i++) begin
      logic r, l, e;
      logic [3:0] a_du, a_dd, a_mu, a_md;
      r = ($urandom_range(0, 63) != 0);
      l = ($urandom_range(0, 7) == 0);
      e = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) begin
        a_du = 4'($urandom_range(0, 15)); a_dd = 4'($urandom_range(0, 15));
        a_mu = 4'($urandom_range(0, 15)); a_md = 4'($urandom_range(0, 15));
      end else begin
        a_du = 4'($urandom_range(0, 9)); a_dd = 4'($urandom_range(0, 3));
        a_mu = 4'($urandom_range(0, 9)); a_md = 4'($urandom_range(0, 1));
      end
      apply(r, l, e, a_du, a_dd, a_mu, a_md);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
